// File: rtl/load_store_unit_if.sv
// Bundle of the CPU request/response channel and the data-memory port of the
// load/store unit. The slave modport is the unit itself; the master modport is
// the environment around it (pipeline MEM stage plus the memory array).
interface load_store_unit_if;
   // CPU request channel
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   // CPU response channel
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   // word-addressed data memory port
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   modport master (
      output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
      output mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_read, mem_write, mem_address, mem_write_data
   );

   modport slave (
      input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
      input  mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_read, mem_write, mem_address, mem_write_data
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word CPU accesses into full-word memory
// traffic. Sub-word stores are read-modify-write; misaligned, out-of-range and
// illegal-size requests complete with an error and never touch memory.
// Every output is a flop loaded together with the next state, so outputs are a
// pure function of the current state and the asynchronous reset clears them
// at once (a reset in WRITE drops mem_write in the same cycle).
module load_store_unit #(
   parameter int MEM_WORDS = 4096
) (
   input logic               clk,
   input logic               rst,
   load_store_unit_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_RMW_RD = 3'd2,
      ST_WRITE  = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   localparam logic [31:0] WORD_LIMIT = 32'(MEM_WORDS);

   state_t      state_r;
   logic [1:0]  lane_r;       // byte offset of the access inside its word
   logic [1:0]  size_r;
   logic        unsigned_r;
   logic [31:0] wdata_r;

   logic        err_s;

   // Select the addressed lane of a memory word and sign/zero extend it.
   function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'b00:   b = word[7:0];
         2'b01:   b = word[15:8];
         2'b10:   b = word[23:16];
         2'b11:   b = word[31:24];
         default: b = 8'h00;
      endcase
      if (lane[1]) begin
         h = word[31:16];
      end else begin
         h = word[15:0];
      end
      case (size)
         2'b00:   r = {{24{b[7] & ~uns}}, b};
         2'b01:   r = {{16{h[15] & ~uns}}, h};
         2'b10:   r = word;
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   // Replace only the addressed byte/halfword lane of a memory word.
   function automatic logic [31:0] merge_store(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic [31:0] wdata);
      logic [31:0] r;
      r = word;
      case (size)
         2'b00: begin
            case (lane)
               2'b00:   r[7:0]   = wdata[7:0];
               2'b01:   r[15:8]  = wdata[7:0];
               2'b10:   r[23:16] = wdata[7:0];
               2'b11:   r[31:24] = wdata[7:0];
               default: r = word;
            endcase
         end
         2'b01: begin
            if (lane[1]) begin
               r[31:16] = wdata[15:0];
            end else begin
               r[15:0] = wdata[15:0];
            end
         end
         2'b10:   r = wdata;
         default: r = word;
      endcase
      return r;
   endfunction

   // Classify the incoming request: alignment, legal size and address range.
   always_comb begin
      err_s = 1'b0;
      case (bus.req_size)
         2'b00:   err_s = 1'b0;
         2'b01:   err_s = bus.req_addr[0];
         2'b10:   err_s = (bus.req_addr[1:0] != 2'b00);
         default: err_s = 1'b1;
      endcase
      if ({2'b00, bus.req_addr[31:2]} >= WORD_LIMIT) begin
         err_s = 1'b1;
      end else begin
         err_s = err_s;
      end
   end

   // Access sequencer: state, captured request and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r            <= ST_IDLE;
         lane_r             <= 2'b00;
         size_r             <= 2'b00;
         unsigned_r         <= 1'b0;
         wdata_r            <= 32'h0000_0000;
         bus.req_ready      <= 1'b1;
         bus.resp_valid     <= 1'b0;
         bus.resp_rdata     <= 32'h0000_0000;
         bus.resp_err       <= 1'b0;
         bus.mem_read       <= 1'b0;
         bus.mem_write      <= 1'b0;
         bus.mem_address    <= 32'h0000_0000;
         bus.mem_write_data <= 32'h0000_0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  lane_r        <= bus.req_addr[1:0];
                  size_r        <= bus.req_size;
                  unsigned_r    <= bus.req_unsigned;
                  wdata_r       <= bus.req_wdata;
                  bus.req_ready <= 1'b0;
                  if (err_s) begin
                     state_r        <= ST_RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= 1'b1;
                     bus.resp_rdata <= 32'h0000_0000;
                  end else if (!bus.req_store) begin
                     state_r         <= ST_LOAD;
                     bus.mem_read    <= 1'b1;
                     bus.mem_address <= {bus.req_addr[31:2], 2'b00};
                  end else if (bus.req_size == 2'b10) begin
                     // full word: nothing to preserve, skip the read
                     state_r            <= ST_WRITE;
                     bus.mem_write      <= 1'b1;
                     bus.mem_write_data <= bus.req_wdata;
                     bus.mem_address    <= {bus.req_addr[31:2], 2'b00};
                  end else begin
                     state_r         <= ST_RMW_RD;
                     bus.mem_read    <= 1'b1;
                     bus.mem_address <= {bus.req_addr[31:2], 2'b00};
                  end
               end else begin
                  state_r       <= ST_IDLE;
                  bus.req_ready <= 1'b1;
               end
            end
            ST_LOAD: begin
               state_r         <= ST_RESP;
               bus.mem_read    <= 1'b0;
               bus.mem_address <= 32'h0000_0000;
               bus.resp_valid  <= 1'b1;
               bus.resp_err    <= 1'b0;
               bus.resp_rdata  <= extract_load(bus.mem_read_data, lane_r,
                                               size_r, unsigned_r);
            end
            ST_RMW_RD: begin
               // mem_address is kept for the write-back of the merged word
               state_r            <= ST_WRITE;
               bus.mem_read       <= 1'b0;
               bus.mem_write      <= 1'b1;
               bus.mem_write_data <= merge_store(bus.mem_read_data, lane_r,
                                                 size_r, wdata_r);
            end
            ST_WRITE: begin
               state_r            <= ST_RESP;
               bus.mem_write      <= 1'b0;
               bus.mem_write_data <= 32'h0000_0000;
               bus.mem_address    <= 32'h0000_0000;
               bus.resp_valid     <= 1'b1;
               bus.resp_err       <= 1'b0;
               bus.resp_rdata     <= 32'h0000_0000;
            end
            ST_RESP: begin
               state_r        <= ST_IDLE;
               bus.resp_valid <= 1'b0;
               bus.resp_err   <= 1'b0;
               bus.resp_rdata <= 32'h0000_0000;
               bus.req_ready  <= 1'b1;
            end
            default: begin
               state_r            <= ST_IDLE;
               bus.req_ready      <= 1'b1;
               bus.resp_valid     <= 1'b0;
               bus.resp_rdata     <= 32'h0000_0000;
               bus.resp_err       <= 1'b0;
               bus.mem_read       <= 1'b0;
               bus.mem_write      <= 1'b0;
               bus.mem_address    <= 32'h0000_0000;
               bus.mem_write_data <= 32'h0000_0000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios followed by random accesses,
// all checked against a byte-array reference memory kept in the bench.
module tb_load_store_unit;

   localparam int MEM_WORDS = 4096;

   logic clk;
   logic rst;
   load_store_unit_if bus ();

   load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // environment memory (what the unit really talks to)
   logic [31:0] mem [0:MEM_WORDS-1];
   logic        pre_we;
   logic [11:0] pre_idx;
   logic [31:0] pre_data;

   // reference memory, byte granular
   logic [7:0]  ref_bytes [0:MEM_WORDS*4-1];

   int vectors;
   int miscompares;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_read_data = bus.mem_read ? mem[bus.mem_address[13:2]] : 32'h0000_0000;

   // memory array: bench preload port plus the unit's write strobe
   always @(posedge clk) begin
      if (pre_we) mem[pre_idx] <= pre_data;
      else if (bus.mem_write) mem[bus.mem_address[13:2]] <= bus.mem_write_data;
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_word(input int idx);
      return {ref_bytes[idx*4+3], ref_bytes[idx*4+2], ref_bytes[idx*4+1], ref_bytes[idx*4]};
   endfunction

   function automatic bit exp_err(input logic [1:0] sz, input logic [31:0] ad);
      if (sz == 2'd3) return 1'b1;
      if (sz == 2'd1 && ad[0]) return 1'b1;
      if (sz == 2'd2 && ad[1:0] != 2'd0) return 1'b1;
      if ((ad >> 2) >= 32'(MEM_WORDS)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit un, input logic [31:0] ad);
      logic [31:0] v;
      int n;
      int base;
      v = 32'h0;
      n = 1 << sz;
      base = int'(ad[13:0]);
      for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[base+i]) << (8*i));
      if (!un && sz == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (!un && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic ref_store(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd);
      int base;
      base = int'(ad[13:0]);
      for (int i = 0; i < (1 << sz); i++) ref_bytes[base+i] = 8'(wd >> (8*i));
   endtask

   task automatic preload(input int idx, input logic [31:0] val);
      @(negedge clk);
      pre_we = 1'b1; pre_idx = 12'(idx); pre_data = val;
      @(posedge clk);
      #1 pre_we = 1'b0;
      for (int i = 0; i < 4; i++) ref_bytes[idx*4+i] = 8'(val >> (8*i));
   endtask

   // one complete access: handshake, strobe/latency tracking, response checks
   task automatic run_req(input bit st, input logic [1:0] sz, input bit un,
                          input logic [31:0] ad, input logic [31:0] wd,
                          output logic [31:0] got_rd);
      bit          e;
      bit          seen;
      int          exp_lat, exp_rds, exp_wrs, lat, rds, wrs;
      logic [31:0] exp_rd;
      e = exp_err(sz, ad);
      exp_rd = 32'h0;
      if (e) begin exp_lat = 1; exp_rds = 0; exp_wrs = 0; end
      else if (!st) begin exp_lat = 2; exp_rds = 1; exp_wrs = 0; exp_rd = ref_load(sz, un, ad); end
      else if (sz == 2'd2) begin exp_lat = 2; exp_rds = 0; exp_wrs = 1; end
      else begin exp_lat = 3; exp_rds = 1; exp_wrs = 1; end

      @(negedge clk);
      check_value("req_ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1; bus.req_store = st; bus.req_size = sz;
      bus.req_unsigned = un; bus.req_addr = ad; bus.req_wdata = wd;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;

      seen = 1'b0; lat = 0; rds = 0; wrs = 0; got_rd = 32'h0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (bus.mem_read) rds++;
         if (bus.mem_write) wrs++;
         if (bus.mem_read || bus.mem_write)
            check_value("mem_address", bus.mem_address, {ad[31:2], 2'b00});
         if (bus.resp_valid) begin
            seen = 1'b1; lat = c; got_rd = bus.resp_rdata;
            check_value("resp_err", 32'(bus.resp_err), 32'(e));
            check_value("resp_rdata", bus.resp_rdata, exp_rd);
            break;
         end
      end
      if (!seen) $display("FAIL resp_timeout: no resp_valid within 8 cycles of accept");
      check_value("latency", 32'(lat), 32'(exp_lat));
      check_value("mem_read_cycles", 32'(rds), 32'(exp_rds));
      check_value("mem_write_cycles", 32'(wrs), 32'(exp_wrs));

      if (st && !e) ref_store(sz, ad, wd);
      if ((ad >> 2) < 32'(MEM_WORDS))
         check_value("mem_word", mem[ad[13:2]], ref_word(int'(ad[13:2])));
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] ad;
      logic [1:0]  sz;
      vectors = 0; miscompares = 0;
      rst = 1'b1; pre_we = 1'b0; pre_idx = 12'h0; pre_data = 32'h0;
      bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'b00;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
      for (int i = 0; i < MEM_WORDS*4; i++) ref_bytes[i] = 8'h00;
      for (int i = 0; i < 64; i++) preload(i, $urandom);

      // reset state
      @(negedge clk);
      check_value("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check_value("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check_value("rst_resp_err", 32'(bus.resp_err), 32'd0);
      check_value("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
      check_value("rst_resp_rdata", bus.resp_rdata, 32'h0);
      check_value("rst_mem_address", bus.mem_address, 32'h0);
      check_value("rst_mem_wdata", bus.mem_write_data, 32'h0);
      rst = 1'b0;

      // loads from known words
      preload(4, 32'h1122_3344);
      preload(8, 32'h8899_AABB);
      run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd); check_value("lw_10", rd, 32'h1122_3344);
      run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd); check_value("lbu_13", rd, 32'h0000_0011);
      run_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, rd); check_value("lbu_10", rd, 32'h0000_0044);
      run_req(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, rd); check_value("lb_20", rd, 32'hFFFF_FFBB);
      run_req(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, rd); check_value("lbu_20", rd, 32'h0000_00BB);
      run_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, rd); check_value("lh_22", rd, 32'hFFFF_8899);
      run_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, rd); check_value("lhu_22", rd, 32'h0000_8899);

      // stores
      run_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234_BEEF, rd);
      check_value("sh_12_word4", mem[4], 32'hBEEF_3344);
      preload(4, 32'h1122_3344);
      run_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00A5, rd);
      check_value("sb_11_word4", mem[4], 32'h1122_A544);
      run_req(1'b1, 2'd2, 1'b0, 32'h14, 32'hDEAD_BEEF, rd);
      check_value("sw_14_word5", mem[5], 32'hDEAD_BEEF);

      // error cases
      run_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, rd);
      run_req(1'b1, 2'd2, 1'b0, 32'h16, 32'h5555_AAAA, rd);
      run_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, rd);
      run_req(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, rd);

      // reset in the WRITE cycle of a word store
      preload(6, 32'hCAFE_F00D);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'd2;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h18; bus.req_wdata = 32'h0BAD_0BAD;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      check_value("rstw_write_before", 32'(bus.mem_write), 32'd1);
      rst = 1'b1;
      #1;
      check_value("rstw_write_dropped", 32'(bus.mem_write), 32'd0);
      check_value("rstw_address", bus.mem_address, 32'h0);
      check_value("rstw_wdata", bus.mem_write_data, 32'h0);
      check_value("rstw_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_value("rstw_no_resp", 32'(bus.resp_valid), 32'd0);
      end
      check_value("rstw_word6", mem[6], 32'hCAFE_F00D);
      run_req(1'b0, 2'd2, 1'b0, 32'h18, 32'h0, rd); check_value("rstw_reload", rd, 32'hCAFE_F00D);

      // random accesses
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 15) == 0) ad = $urandom | 32'h0001_0000;
         else ad = 32'($urandom_range(0, 64*4-1));
         if ($urandom_range(0, 15) == 0) sz = 2'd3;
         else sz = 2'($urandom_range(0, 2));
         run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
